// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns local commands into pipelined SINGLE / INCRx / WRAPx transfers.
// Build option AHB_MGR_ERR_CONTINUE_EN: keep issuing the remaining burst beats after ERROR.
module ahb_lite_manager #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StErr2} state_e;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst[2:1])
      2'b01:   burst_beats = 5'd4;
      2'b10:   burst_beats = 5'd8;
      2'b11:   burst_beats = 5'd16;
      default: burst_beats = 5'd1;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic [1:0]              htrans_q, htrans_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [2:0]              hburst_q, hburst_d;
  logic [DATA_WIDTH-1:0]   hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [3:0]              beats_left_q, beats_left_d;
  logic                    err_flag_q, err_flag_d;
  logic                    dphase_q, dphase_d;
  logic                    dphase_write_q, dphase_write_d;

  logic                    dphase_err, cancel, addr_done, rd_ok, is_wrap;
  logic [ADDR_WIDTH-1:0]   size_bytes, wrap_mask, incr_addr, next_addr;

  assign dphase_err = dphase_q && (HRESP == 2'b01);
`ifdef AHB_MGR_ERR_CONTINUE_EN
  assign cancel = 1'b0;
`else
  assign cancel = dphase_err;
`endif
  // A cancelling ERROR also blocks an address phase that would complete alongside it.
  assign addr_done = HREADY && htrans_q[1] && !cancel;
  assign rd_ok     = dphase_q && !dphase_write_q && HREADY && (HRESP == 2'b00) &&
                     (state_q != StErr2);

  assign size_bytes = AddrOne << hsize_q;
  assign wrap_mask  = (ADDR_WIDTH'(burst_beats(hburst_q)) << hsize_q) - AddrOne;
  assign incr_addr  = haddr_q + size_bytes;
  assign is_wrap    = !hburst_q[0] && (hburst_q != 3'b000);
  assign next_addr  = is_wrap ? ((haddr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;

  always_comb begin
    state_d        = state_q;
    haddr_d        = haddr_q;
    htrans_d       = htrans_q;
    hwrite_d       = hwrite_q;
    hsize_d        = hsize_q;
    hburst_d       = hburst_q;
    hwdata_d       = hwdata_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    beats_left_d   = beats_left_q;
    err_flag_d     = err_flag_q | dphase_err;
    dphase_d       = dphase_q;
    dphase_write_d = dphase_write_q;

    if (addr_done) begin
      dphase_d       = 1'b1;
      dphase_write_d = hwrite_q;
    end else if (HREADY) begin
      dphase_d = 1'b0;
    end
    if (addr_done && hwrite_q) hwdata_d = wr_data;
    if (rd_ok) begin
      rd_valid_d = 1'b1;
      rd_data_d  = HRDATA;
    end

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          htrans_d     = TransNonseq;
          haddr_d      = cmd_addr & ~((AddrOne << cmd_size) - AddrOne);
          hwrite_d     = cmd_write;
          hsize_d      = cmd_size;
          hburst_d     = (cmd_burst == 3'b001) ? 3'b000 : cmd_burst;
          beats_left_d = 4'(burst_beats(cmd_burst) - 5'd1);
          err_flag_d   = 1'b0;
          state_d      = StXfer;
        end
      end
      StXfer: begin
        if (cancel) begin
          htrans_d     = TransIdle;
          beats_left_d = '0;
          if (HREADY) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StErr2;
          end
        end else if (addr_done) begin
          if (beats_left_q != 4'd0) begin
            htrans_d     = TransSeq;
            haddr_d      = next_addr;
            beats_left_d = beats_left_q - 4'd1;
          end else begin
            htrans_d = TransIdle;
            state_d  = StDrain;
          end
        end
      end
      StDrain: begin
        if (HREADY) begin
          done_d  = 1'b1;
          err_d   = err_flag_q | dphase_err;
          state_d = StIdle;
        end else if (cancel) begin
          state_d = StErr2;
        end
      end
      StErr2: begin
        if (HREADY) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= StIdle;
      haddr_q        <= '0;
      htrans_q       <= TransIdle;
      hwrite_q       <= 1'b0;
      hsize_q        <= 3'b000;
      hburst_q       <= 3'b000;
      hwdata_q       <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      beats_left_q   <= '0;
      err_flag_q     <= 1'b0;
      dphase_q       <= 1'b0;
      dphase_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      haddr_q        <= haddr_d;
      htrans_q       <= htrans_d;
      hwrite_q       <= hwrite_d;
      hsize_q        <= hsize_d;
      hburst_q       <= hburst_d;
      hwdata_q       <= hwdata_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      beats_left_q   <= beats_left_d;
      err_flag_q     <= err_flag_d;
      dphase_q       <= dphase_d;
      dphase_write_q <= dphase_write_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign wr_data_pop = addr_done && hwrite_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager with a scripted subordinate and scoreboard queues.
module tb_ahb_lite_manager;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size, cmd_burst;
  logic [31:0] wr_data;
  logic        wr_data_pop;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  always #5 HCLK = ~HCLK;

  ahb_lite_manager #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_data_pop(wr_data_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] exp_addr_q [$];
  logic [31:0] exp_wdata_q [$];
  logic [31:0] exp_rd_q [$];
  logic [31:0] wbase;
  int          wr_idx;
  logic        dp_valid, dp_write;
  logic [31:0] dp_addr;

  function automatic logic [31:0] rdpat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " HTRANS"}, HTRANS, 0);
    check({tag, " HADDR"}, HADDR, 0);
    check({tag, " HWRITE"}, HWRITE, 0);
    check({tag, " HSIZE"}, HSIZE, 0);
    check({tag, " HBURST"}, HBURST, 0);
    check({tag, " HWDATA"}, HWDATA, 0);
    check({tag, " rd_data"}, rd_data, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " wr_data_pop"}, wr_data_pop, 0);
    check({tag, " cmd_ready"}, cmd_ready, 1);
  endtask

  // Push expected completed address phases and data beats for one command.
  task automatic push_expect(input logic write, input logic [31:0] addr, input int size,
                             input int beats, input bit wrap, input int n_addr,
                             input int n_data);
    logic [31:0] bytes, len, base, a;
    bytes = 32'(1) << size;
    len   = 32'(beats) * bytes;
    base  = addr & ~(len - 32'd1);
    for (int i = 0; i < n_addr; i++) begin
      if (wrap) a = base + ((addr - base + 32'(i) * bytes) % len);
      else      a = addr + 32'(i) * bytes;
      exp_addr_q.push_back({(i == 0) ? 2'b10 : 2'b11, a});
      if (i < n_data) begin
        if (write) exp_wdata_q.push_back(wbase + 32'(i) * 32'h0101_0101);
        else       exp_rd_q.push_back(rdpat(a));
      end
    end
  endtask

  task automatic issue(input logic write, input logic [31:0] addr, input logic [2:0] size,
                       input logic [2:0] burst, input string name);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_burst = burst;
    wr_idx    = 0;
    wr_data   = wbase;
    HREADY    = 1'b1;
    HRESP     = 2'b00;
    @(negedge HCLK);
    check({name, " cmd_ready"}, cmd_ready, 1);
    @(posedge HCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic write, input logic [31:0] addr,
                         input logic [2:0] size, input logic [2:0] burst, input int beats,
                         input bit wrap, input int n_addr, input int n_data,
                         input int stall_c, input int stall_n, input int err_c,
                         input int idle_c, input int done_c, input logic exp_err,
                         input int exp_pops, input logic [2:0] hb_exp);
    int          pops;
    bit          seen, pop_now, nxt_v, nxt_w;
    logic [31:0] nxt_a;
    logic [33:0] head;
    pops = 0;
    seen = 0;
    push_expect(write, addr, int'(size), beats, wrap, n_addr, n_data);
    issue(write, addr, size, burst, name);
    for (int c = 0; c < 100 && !seen; c++) begin
      HREADY = 1'b1;
      HRESP  = 2'b00;
      if (stall_c >= 0 && c >= stall_c && c < stall_c + stall_n) HREADY = 1'b0;
      if (err_c >= 0 && c == err_c) begin HREADY = 1'b0; HRESP = 2'b01; end
      if (err_c >= 0 && c == err_c + 1) begin HREADY = 1'b1; HRESP = 2'b01; end
      HRDATA = (dp_valid && !dp_write) ? rdpat(dp_addr) : 32'h0;
      @(negedge HCLK);
      pop_now = wr_data_pop;
      if (c == idle_c) check({name, " HTRANS idle"}, HTRANS, 0);
      if (HTRANS[1]) begin
        if (HREADY) begin
          if (exp_addr_q.size() == 0) begin
            check({name, " unexpected addr phase"}, HADDR, 32'hFFFF_FFFF);
          end else begin
            head = exp_addr_q.pop_front();
            check({name, " HTRANS"}, HTRANS, head[33:32]);
            check({name, " HADDR"}, HADDR, head[31:0]);
            check({name, " HBURST"}, HBURST, hb_exp);
          end
        end else if (exp_addr_q.size() != 0) begin
          head = exp_addr_q[0];
          check({name, " HADDR held"}, HADDR, head[31:0]);
        end
      end
      if (dp_valid && dp_write && HREADY) begin
        if (exp_wdata_q.size() == 0) check({name, " extra wdata"}, HWDATA, 32'hFFFF_FFFF);
        else check({name, " HWDATA"}, HWDATA, exp_wdata_q.pop_front());
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) check({name, " extra rd_valid"}, rd_data, 32'hFFFF_FFFF);
        else check({name, " rd_data"}, rd_data, exp_rd_q.pop_front());
      end
      if (pop_now) pops++;
      if (done) begin
        seen = 1;
        check({name, " done cycle"}, c, done_c);
        check({name, " err"}, err, exp_err);
      end
      nxt_v = dp_valid;
      nxt_w = dp_write;
      nxt_a = dp_addr;
      if (HREADY && HTRANS[1]) begin
        nxt_v = 1;
        nxt_w = HWRITE;
        nxt_a = HADDR;
      end else if (HREADY) begin
        nxt_v = 0;
      end
      @(posedge HCLK);
      #1;
      dp_valid = nxt_v;
      dp_write = nxt_w;
      dp_addr  = nxt_a;
      if (pop_now) wr_idx++;
      wr_data = wbase + 32'(wr_idx) * 32'h0101_0101;
    end
    check({name, " done seen"}, seen, 1);
    check({name, " pops"}, pops, exp_pops);
    check({name, " addr left"}, exp_addr_q.size(), 0);
    check({name, " wdata left"}, exp_wdata_q.size(), 0);
    check({name, " rdata left"}, exp_rd_q.size(), 0);
    exp_addr_q.delete();
    exp_wdata_q.delete();
    exp_rd_q.delete();
    HREADY = 1'b1;
    HRESP  = 2'b00;
  endtask

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_burst = '0;
    wr_data   = '0;
    HRDATA    = '0;
    HREADY    = 1'b1;
    HRESP     = 2'b00;
    wbase     = '0;
    wr_idx    = 0;
    dp_valid  = 1'b0;
    dp_write  = 1'b0;
    dp_addr   = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check_reset("reset");
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // SINGLE word write.
    wbase = 32'hDEAD_BEEF;
    run_cmd("single_wr", 1'b1, 32'h100, 3'd2, 3'b000, 1, 0, 1, 1,
            -1, 0, -1, 1, 2, 1'b0, 1, 3'b000);
    // INCR4 word read, two wait states in beat 2 data phase.
    run_cmd("incr4_rd", 1'b0, 32'h20, 3'd2, 3'b011, 4, 0, 4, 4,
            2, 2, -1, -1, 7, 1'b0, 0, 3'b011);
    // WRAP4 word read.
    run_cmd("wrap4_rd", 1'b0, 32'h38, 3'd2, 3'b010, 4, 1, 4, 4,
            -1, 0, -1, -1, 5, 1'b0, 0, 3'b010);
    // WRAP8 halfword write.
    wbase = 32'h1000_0001;
    run_cmd("wrap8_wr", 1'b1, 32'h0A, 3'd1, 3'b100, 8, 1, 8, 8,
            -1, 0, -1, -1, 9, 1'b0, 8, 3'b100);
    // INCR8 word write with ERROR on beat 3 data phase.
    wbase = 32'h5000_0000;
`ifdef AHB_MGR_ERR_CONTINUE_EN
    run_cmd("incr8_err", 1'b1, 32'h0, 3'd2, 3'b101, 8, 0, 8, 8,
            -1, 0, 3, -1, 10, 1'b1, 8, 3'b101);
`else
    run_cmd("incr8_err", 1'b1, 32'h0, 3'd2, 3'b101, 8, 0, 3, 3,
            -1, 0, 3, 4, 5, 1'b1, 3, 3'b101);
`endif
    // Undefined-length INCR runs as a single beat with HBURST=SINGLE.
    wbase = 32'h0BAD_F00D;
    run_cmd("incr_undef", 1'b1, 32'h204, 3'd2, 3'b001, 1, 0, 1, 1,
            -1, 0, -1, 1, 2, 1'b0, 1, 3'b000);

    // Reset in the middle of an INCR16 read while beat 5 is on the bus.
    issue(1'b0, 32'h400, 3'd2, 3'b111, "incr16_rst");
    repeat (4) @(posedge HCLK);
    #2;
    check("incr16_rst beat5 HTRANS", HTRANS, 2'b11);
    check("incr16_rst beat5 HADDR", HADDR, 32'h410);
    HRESETn = 1'b0;
    #1;
    check_reset("midburst_reset");
    dp_valid = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("post_reset cmd_ready", cmd_ready, 1);
    @(posedge HCLK);
    #1;
    run_cmd("single_rd", 1'b0, 32'h44, 3'd2, 3'b000, 1, 0, 1, 1,
            -1, 0, -1, 1, 2, 1'b0, 0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_manager.md
Name: ahb_lite_manager

Overview:
AHB-Lite manager (initiator) that turns a simple local command interface into pipelined AHB-Lite transfers. It drives the address and control signals and HWDATA, and consumes HRDATA, HREADY and HRESP from the subordinate side. This includes the default subordinate and its two-cycle ERROR response. Supported transfers are SINGLE and fixed-length INCR/WRAP bursts.

Parameters:
ADDR_WIDTH, 32, width of HADDR and cmd_addr
DATA_WIDTH, 32, width of HWDATA/HRDATA/wr_data/rd_data (32 or 64)

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  start address
cmd_size  in  3  HSIZE value for all beats
cmd_burst  in  3  HBURST encoding
wr_data  in  DATA_WIDTH  next write beat data (FIFO-head style)
wr_data_pop  out  1  wr_data consumed this cycle
rd_data  out  DATA_WIDTH  read beat data
rd_valid  out  1  rd_data valid (one-cycle pulse)
done  out  1  one-cycle pulse at end of command
err  out  1  valid with done; 1 = any beat got ERROR
HADDR  out  ADDR_WIDTH  address
HTRANS  out  2  IDLE=00, BUSY=01 (never driven), NONSEQ=10, SEQ=11
HWRITE  out  1
HSIZE  out  3
HBURST  out  3
HWDATA  out  DATA_WIDTH
HRDATA  in  DATA_WIDTH
HREADY  in  1
HRESP  in  2  00=OKAY, 01=ERROR

Behaviour:
- Reset (async, any state): HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, rd_data=0, rd_valid=0, done=0, err=0, wr_data_pop=0, cmd_ready=1, state=IDLE, beat counter=0.
- All AHB outputs are registered.
- States: IDLE, XFER (address phases outstanding), DRAIN (final data phase only), ERR2 (second error cycle pending).
- IDLE: cmd_ready=1. On accept at edge k, the first beat is visible after edge k: HTRANS=NONSEQ, HADDR=cmd_addr with low log2(bytes) bits forced to 0, plus HWRITE/HSIZE/HBURST. Next state is XFER. cmd_ready=0 outside IDLE.
- Beats: SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16. cmd_burst=001 (undefined INCR) is executed as SINGLE with HBURST driven 000.
- An address phase completes on an edge with HREADY=1 and HTRANS NONSEQ/SEQ. On that edge the block:
  - moves that beat into the data phase;
  - for writes, registers HWDATA<=wr_data and pulses wr_data_pop in the same cycle (combinational on HREADY && active HTRANS && HWRITE);
  - presents the next beat if one remains: HTRANS=SEQ, HADDR advanced by 1<<HSIZE. Otherwise HTRANS=IDLE and next state is DRAIN.
- While HREADY=0, all address/control and HWDATA are held.
- INCR addressing is a plain add. WRAP addressing: boundary = beats*(1<<HSIZE); bits below the boundary increment modulo, bits above are held.
- 1 KB boundary crossing and HSIZE > log2(DATA_WIDTH/8) are caller errors and are not checked.
- Read data phase complete (HREADY=1, HRESP=00): rd_data<=HRDATA and rd_valid=1 for one cycle.
- DRAIN: on final data phase completion, pulse done; err=sticky error flag; return to IDLE, where cmd_ready=1 the next cycle.
- Error, first cycle (HRESP=01, HREADY=0):
  - HTRANS<=IDLE on the next edge; the outstanding burst is cancelled;
  - the cancelled next beat is not popped;
  - sticky error flag is set;
  - next state is ERR2.
- ERR2: on HREADY=1, pulse done with err=1; no rd_valid for the errored beat; go to IDLE.
- ERROR with HREADY=1 (protocol violation): treated as the second error cycle.
- Zero-wait SINGLE: done asserted 2 cycles after accept edge.
- Back-to-back commands: the new NONSEQ follows only after done (one IDLE bus cycle minimum).

Optional Feature:
AHB_MGR_ERR_CONTINUE_EN
- Defined: on ERROR, remaining burst beats continue. HTRANS is not forced to IDLE, pops continue for all beats, err is sticky, and done occurs after the last beat.
- Undefined: cancel behaviour as above.

Test Plan:
1. SINGLE write to 0x100, wr_data=0xDEADBEEF, HREADY=1 -> HTRANS=10, HADDR=0x100 for 1 cycle; HWDATA=0xDEADBEEF next cycle; one wr_data_pop; done 2 cycles after accept; err=0.
2. INCR4 word read at 0x20, HREADY=0 for 2 cycles during beat 2 data phase -> HADDR 0x20,0x24,0x28,0x2C (0x28 held during the wait); HTRANS 10,11,11,11; 4 rd_valid with HRDATA values; done, err=0.
3. WRAP4 word read at 0x38 -> HADDR 0x38,0x3C,0x30,0x34; HBURST=010.
4. WRAP8 halfword write at 0x0A -> HADDR 0x0A,0x0C,0x0E,0x00,0x02,0x04,0x06,0x08; 8 pops.
5. INCR8 word write at 0x0, HRESP=01 two cycles on beat 3 data phase -> HTRANS=00 in second error cycle; 3 pops total; done with err=1. With AHB_MGR_ERR_CONTINUE_EN: 8 pops, done after beat 8, err=1.
6. HRESETn low mid-INCR16 read at beat 5 -> all outputs at reset values immediately; cmd_ready=1 after release; new SINGLE read completes normally.
